// File: rtl/icache_intc_bank_arbiter.sv
// Per-bank request arbiter for the instruction-cache interconnect.
// Round-robin selects one fetch port per cycle toward the bank. The winner of every
// accepted request goes into an in-order FIFO, so bank responses go back to the right port.
module icache_intc_bank_arbiter #(
  parameter int unsigned N_FETCH         = 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned ID_WIDTH       = $clog2(N_FETCH)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_FETCH-1:0]                  req_i,
  input  logic [N_FETCH-1:0][ADDR_WIDTH-1:0]  addr_i,
  output logic [N_FETCH-1:0]                  gnt_o,
  output logic [N_FETCH-1:0]                  r_valid_o,
  output logic [DATA_WIDTH-1:0]               r_rdata_o,
  output logic                                bank_req_o,
  output logic [ADDR_WIDTH-1:0]               bank_addr_o,
  output logic [ID_WIDTH-1:0]                 bank_id_o,
  input  logic                                bank_gnt_i,
  input  logic                                bank_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               bank_rdata_i,
  output logic                                err_o
);

  localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                err_q, err_d;
  logic                can_push;
  logic                push;
  logic                pop;
  logic [ID_WIDTH-1:0] head;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return ptr + PtrWidth'(1);
  endfunction

  // Round-robin scan: first requesting port at or above rr_ptr, wrapping around.
  always_comb begin
    int unsigned         idx;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N_FETCH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_FETCH) begin
        idx = idx - N_FETCH;
      end
      cand = ID_WIDTH'(idx);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Request, grant and response routing.
  always_comb begin
    // A pop in the same cycle frees a slot even when the FIFO is full.
    can_push    = (count_q < CntWidth'(MAX_OUTSTANDING)) | bank_rvalid_i;
    bank_req_o  = (|req_i) & can_push;
    bank_addr_o = addr_i[winner];
    bank_id_o   = winner;
    push        = bank_req_o & bank_gnt_i;
    gnt_o       = push ? (N_FETCH'(1) << winner) : '0;
    head        = fifo_q[rd_ptr_q];
    pop         = bank_rvalid_i & (count_q != '0);
    r_valid_o   = pop ? (N_FETCH'(1) << head) : '0;
    r_rdata_o   = bank_rdata_i;
    err_o       = err_q;
  end

  // Next-state for priority pointer, FIFO bookkeeping and sticky error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A response with nothing outstanding is flagged, even if a push lands this cycle.
    err_d    = err_q | (bank_rvalid_i & (count_q == '0));
    if (push) begin
      rr_ptr_d = (winner == ID_WIDTH'(N_FETCH - 1)) ? '0 : winner + ID_WIDTH'(1);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all outstanding entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= winner;
      end
    end
  end

endmodule

// File: tb/tb_icache_intc_bank_arbiter.sv
// Bench for icache_intc_bank_arbiter: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_icache_intc_bank_arbiter;

  localparam int N   = 4;
  localparam int MAX = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  addr_i;
  logic [N-1:0]          gnt_o;
  logic [N-1:0]          r_valid_o;
  logic [DW-1:0]         r_rdata_o;
  logic                  bank_req_o;
  logic [AW-1:0]         bank_addr_o;
  logic [1:0]            bank_id_o;
  logic                  bank_gnt_i;
  logic                  bank_rvalid_i;
  logic [DW-1:0]         bank_rdata_i;
  logic                  err_o;

  int checks = 0;
  int errors = 0;

  icache_intc_bank_arbiter #(
    .N_FETCH         (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .gnt_o         (gnt_o),
    .r_valid_o     (r_valid_o),
    .r_rdata_o     (r_rdata_o),
    .bank_req_o    (bank_req_o),
    .bank_addr_o   (bank_addr_o),
    .bank_id_o     (bank_id_o),
    .bank_gnt_i    (bank_gnt_i),
    .bank_rvalid_i (bank_rvalid_i),
    .bank_rdata_i  (bank_rdata_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding port numbers, a priority index, a sticky flag.
  int m_q[$];
  int m_rr;
  bit m_err;

  function automatic int m_win(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  int u_w;
  bit u_hs;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      u_w  = m_win(req_i, m_rr);
      u_hs = (u_w >= 0) && ((m_q.size() < MAX) || bank_rvalid_i) && bank_gnt_i;
      if (bank_rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (u_hs) begin
        m_q.push_back(u_w);
        m_rr = (u_w + 1) % N;
      end
    end
  end

  int           c_w;
  bit           c_breq;
  logic [N-1:0] c_gnt;
  logic [N-1:0] c_rv;
  always @(negedge clk_i) begin
    c_w    = m_win(req_i, m_rr);
    c_breq = (c_w >= 0) && ((m_q.size() < MAX) || bank_rvalid_i);
    c_gnt  = (c_breq && bank_gnt_i) ? (4'b0001 << c_w) : 4'b0000;
    c_rv   = (bank_rvalid_i && m_q.size() > 0) ? (4'b0001 << m_q[0]) : 4'b0000;
    chk("model gnt_o", 32'(gnt_o), 32'(c_gnt));
    chk("model r_valid_o", 32'(r_valid_o), 32'(c_rv));
    chk("model bank_req_o", 32'(bank_req_o), 32'(c_breq));
    chk("model r_rdata_o", r_rdata_o, bank_rdata_i);
    chk("model err_o", 32'(err_o), 32'(m_err));
    if (c_breq) begin
      chk("model bank_addr_o", bank_addr_o, addr_i[c_w]);
      chk("model bank_id_o", 32'(bank_id_o), 32'(c_w));
    end
  end

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    #1;
  endtask

  task automatic reset_pulse();
    rst_ni = 1'b0;
    at_neg();
    chk("reset bank_req_o", 32'(bank_req_o), 32'd0);
    chk("reset err_o", 32'(err_o), 32'd0);
    next_cyc();
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_i         = '0;
    bank_gnt_i    = 1'b0;
    bank_rvalid_i = 1'b0;
    bank_rdata_i  = '0;
    addr_i[0]     = 32'h0000_1000;
    addr_i[1]     = 32'h0000_1010;
    addr_i[2]     = 32'h0000_1020;
    addr_i[3]     = 32'h0000_1030;

    // Reset state, idle inputs.
    at_neg();
    chk("idle gnt_o", 32'(gnt_o), 32'd0);
    chk("idle r_valid_o", 32'(r_valid_o), 32'd0);
    chk("idle bank_req_o", 32'(bank_req_o), 32'd0);
    chk("idle err_o", 32'(err_o), 32'd0);
    next_cyc();
    rst_ni = 1'b1;

    // Rotation with a response one cycle after each grant.
    req_i      = 4'b1111;
    bank_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bank_rvalid_i = (i > 0);
      bank_rdata_i  = 32'hD000_0000 + 32'(i);
      at_neg();
      chk("rot gnt_o", 32'(gnt_o), 32'(4'b0001 << (i % 4)));
      chk("rot r_valid_o", 32'(r_valid_o), (i == 0) ? 32'd0 : 32'(4'b0001 << ((i - 1) % 4)));
      chk("rot r_rdata_o", r_rdata_o, 32'hD000_0000 + 32'(i));
      next_cyc();
    end
    req_i = '0;
    at_neg();
    chk("rot drain r_valid_o", 32'(r_valid_o), 32'h1);
    chk("rot drain gnt_o", 32'(gnt_o), 32'h0);
    next_cyc();
    bank_rvalid_i = 1'b0;

    reset_pulse();

    // Full stall, then push and pop together while full.
    req_i      = 4'b0101;
    bank_gnt_i = 1'b1;
    at_neg();
    chk("full gnt1", 32'(gnt_o), 32'h1);
    next_cyc();
    at_neg();
    chk("full gnt2", 32'(gnt_o), 32'h4);
    next_cyc();
    at_neg();
    chk("full bank_req_o", 32'(bank_req_o), 32'h0);
    chk("full gnt_o", 32'(gnt_o), 32'h0);
    next_cyc();
    bank_rvalid_i = 1'b1;
    at_neg();
    chk("full pop r_valid_o", 32'(r_valid_o), 32'h1);
    chk("full push gnt_o", 32'(gnt_o), 32'h1);
    next_cyc();
    req_i = '0;
    at_neg();
    chk("full drain1", 32'(r_valid_o), 32'h4);
    next_cyc();
    at_neg();
    chk("full drain2", 32'(r_valid_o), 32'h1);
    next_cyc();
    bank_rvalid_i = 1'b0;

    // Bank stall: port 1 waits three cycles, priority index currently 1.
    req_i      = 4'b0010;
    bank_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall bank_req_o", 32'(bank_req_o), 32'h1);
      chk("stall bank_addr_o", bank_addr_o, 32'h0000_1010);
      chk("stall gnt_o", 32'(gnt_o), 32'h0);
      next_cyc();
    end
    bank_gnt_i = 1'b1;
    at_neg();
    chk("stall grant", 32'(gnt_o), 32'h2);
    next_cyc();
    req_i      = 4'b1111;
    bank_gnt_i = 1'b0;
    at_neg();
    chk("stall rr_ptr via id", 32'(bank_id_o), 32'h2);
    next_cyc();
    req_i         = '0;
    bank_rvalid_i = 1'b1;
    at_neg();
    chk("stall response", 32'(r_valid_o), 32'h2);
    next_cyc();

    // Spurious response on an empty FIFO.
    at_neg();
    chk("spur r_valid_o", 32'(r_valid_o), 32'h0);
    chk("spur err same cycle", 32'(err_o), 32'h0);
    next_cyc();
    bank_rvalid_i = 1'b0;
    at_neg();
    chk("spur err set", 32'(err_o), 32'h1);
    next_cyc();
    at_neg();
    chk("spur err sticky", 32'(err_o), 32'h1);
    next_cyc();

    reset_pulse();
    at_neg();
    chk("err cleared", 32'(err_o), 32'h0);
    next_cyc();

    // Reset with two grants outstanding.
    req_i      = 4'b0101;
    bank_gnt_i = 1'b1;
    at_neg();
    chk("mid gnt1", 32'(gnt_o), 32'h1);
    next_cyc();
    at_neg();
    chk("mid gnt2", 32'(gnt_o), 32'h4);
    next_cyc();
    req_i      = '0;
    bank_gnt_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    req_i = 4'b1111;
    #1;
    chk("mid async id", 32'(bank_id_o), 32'h0);
    chk("mid async bank_req_o", 32'(bank_req_o), 32'h1);
    req_i = '0;
    next_cyc();
    rst_ni        = 1'b1;
    bank_rvalid_i = 1'b1;
    at_neg();
    chk("mid r_valid_o", 32'(r_valid_o), 32'h0);
    next_cyc();
    bank_rvalid_i = 1'b0;
    at_neg();
    chk("mid err_o", 32'(err_o), 32'h1);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_intc_bank_arbiter.md
Name: icache_intc_bank_arbiter

Overview:
- Per-bank request arbiter for the instruction-cache interconnect.
- Shares one cache bank among N_FETCH fetch ports using round-robin arbitration.
- Records the winner of every accepted request in an in-order tracking FIFO, so the bank's response is routed back to the correct fetch port.
- Sits between the request-side decoders (one request per fetch port toward this bank) and the cache bank. Instantiated once per bank.

Parameters:
- N_FETCH, 8, number of fetch ports (requesters); must be ≥2.
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, response data width.
- MAX_OUTSTANDING, 2, tracking-FIFO depth; must be ≥1.
- ID_WIDTH, $clog2(N_FETCH), winner index width (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  N_FETCH  per-port request.
- addr_i  in  N_FETCH x ADDR_WIDTH  per-port fetch address.
- gnt_o  out  N_FETCH  per-port grant, one-hot or zero.
- r_valid_o  out  N_FETCH  per-port response valid, one-hot or zero.
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all ports.
- bank_req_o  out  1  request to cache bank.
- bank_addr_o  out  ADDR_WIDTH  address of the selected port.
- bank_id_o  out  ID_WIDTH  winner index, for debug and performance counters.
- bank_gnt_i  in  1  bank accepts the request.
- bank_rvalid_i  in  1  bank response valid; responses are in order.
- bank_rdata_i  in  DATA_WIDTH  bank response data.
- err_o  out  1  sticky flag: response arrived with no outstanding request.

Behaviour:
- Single clock domain. rst_ni is asynchronous, active-low; deassertion is synchronised upstream.
- Reset state: rr_ptr=0, FIFO empty (count=0, rd/wr pointers 0), err_o=0.
  - With no inputs active, gnt_o=0, r_valid_o=0, bank_req_o=0.
  - bank_addr_o and bank_id_o are don't-care when bank_req_o=0; drive index 0.
- Winner selection (combinational):
  - Scan from rr_ptr upward, wrapping modulo N_FETCH.
  - The first port with req_i=1 wins; winner = that index.
- bank_req_o = |req_i & can_push, where can_push = (count<MAX_OUTSTANDING) | bank_rvalid_i. A same-cycle pop frees a slot.
- bank_addr_o = addr_i[winner]; bank_id_o = winner.
- gnt_o[winner] = bank_req_o & bank_gnt_i; all other bits are 0.
  - This is a zero-latency combinational path from req_i and bank_gnt_i.
- Handshake (bank_req_o & bank_gnt_i) at a clock edge:
  - Push winner into the FIFO.
  - rr_ptr <= (winner+1) mod N_FETCH. When winner = N_FETCH-1, rr_ptr wraps to 0.
  - With no handshake, rr_ptr holds. A request that is not granted does not move priority.
- Requests held while the FIFO is full are not granted. Requesters keep req_i and addr_i stable until granted (interconnect protocol).
- Response path (combinational):
  - When bank_rvalid_i=1 and count>0: r_valid_o[fifo_head]=1 and the head is popped at the edge.
  - r_rdata_o = bank_rdata_i at all times.
- Empty-FIFO response: bank_rvalid_i=1 with count=0 → r_valid_o stays 0, nothing is popped, and err_o is set at the edge. err_o stays set until reset.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - Allowed even when count=MAX_OUTSTANDING, through the can_push term.
  - When count=0, a same-cycle push does not satisfy that cycle's response; the error rule applies.
- FIFO pointers wrap modulo MAX_OUTSTANDING. count ranges 0..MAX_OUTSTANDING, and its width accommodates the full value.
- Reset mid-operation: all outstanding entries are discarded and no r_valid_o follows. The bank is reset in the same domain.

Test Plan (N_FETCH=4, MAX_OUTSTANDING=2):
- Reset, idle → gnt_o=0, r_valid_o=0, bank_req_o=0, err_o=0, rr_ptr=0.
- Rotation: req_i=4'b1111 held, bank_gnt_i=1, bank_rvalid_i=1 one cycle after each grant → gnt_o sequence 0001,0010,0100,1000,0001. r_valid_o mirrors the grant one cycle later. r_rdata_o tracks bank_rdata_i.
- Full stall: req_i=4'b0101, bank_gnt_i=1, bank_rvalid_i=0 → two grants (0001, then 0100). The third cycle has bank_req_o=0 and gnt_o=0. Asserting bank_rvalid_i then gives r_valid_o=0001, with a same-cycle grant of 0001 (push+pop while full).
- Bank stall: req_i=4'b0010, bank_gnt_i=0 for 3 cycles → bank_req_o=1, bank_addr_o=addr_i[1], gnt_o=0, rr_ptr unchanged. Granting on the 4th cycle gives gnt_o=0010 and rr_ptr=2.
- Spurious response: FIFO empty, bank_rvalid_i pulse → r_valid_o=0, err_o=1 from the next cycle until rst_ni=0.
- Reset mid-flight: two grants outstanding, pulse rst_ni low asynchronously → FIFO empty and rr_ptr=0 immediately. A later bank_rvalid_i sets err_o and produces no r_valid_o.
